// File: rtl/blit_pkg.sv
// Shared constants for the sprite blitter: default sprite and framebuffer
// dimensions, the transparent colour key and the FSM state encodings.
package blit_pkg;

  localparam int SPR_W_D  = 34;
  localparam int SPR_H_D  = 27;
  localparam int ROM_AW_D = 10;
  localparam int FB_W_D   = 160;
  localparam int FB_H_D   = 120;
  localparam int FB_AW_D  = 15;

  localparam logic [7:0] TRANSP_D = 8'h00;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/blit_addr_gen.sv
// Sprite walk counters: col/row, ROM address (raster or mirrored),
// FB row base accumulator and last-pixel flag.
// Ports: i_clr loads start values (row base = i_base0), i_step advances.
module blit_addr_gen
  import blit_pkg::*;
#(
  parameter int SPR_W  = SPR_W_D,
  parameter int SPR_H  = SPR_H_D,
  parameter int ROM_AW = ROM_AW_D,
  parameter int FB_W   = FB_W_D,
  parameter int FB_AW  = FB_AW_D,
  parameter int CW     = $clog2(SPR_W),
  parameter int RW     = $clog2(SPR_H)
) (
  input  logic              i_clk2,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_step,
  input  logic              i_mirror,
  input  logic [FB_AW-1:0]  i_base0,
  output logic [ROM_AW-1:0] o_rom_addr,
  output logic [CW-1:0]     o_col,
  output logic [RW-1:0]     o_row,
  output logic [FB_AW-1:0]  o_row_base,
  output logic              o_last
);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ROM_AW-1:0] rrom_q, rrom_d;
  logic [FB_AW-1:0]  base_q, base_d;

  logic              col_end;

  assign col_end = (col_q == CW'(SPR_W - 1));
  assign o_last  = col_end && (row_q == RW'(SPR_H - 1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    rrom_d = rrom_q;
    base_d = base_q;
    if (i_clr) begin
      col_d  = '0;
      row_d  = '0;
      rrom_d = '0;
      base_d = i_base0;
    end else if (i_step) begin
      if (o_last) begin
        col_d  = '0;
        row_d  = '0;
        rrom_d = '0;
      end else if (col_end) begin
        col_d  = '0;
        row_d  = row_q + RW'(1);
        rrom_d = rrom_q + ROM_AW'(SPR_W);
        base_d = base_q + FB_AW'(FB_W);
      end else begin
        col_d  = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      col_q  <= '0;
      row_q  <= '0;
      rrom_q <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      rrom_q <= rrom_d;
      base_q <= base_d;
    end
  end

  // Mirrored rows read right-to-left; destination order is unchanged.
  assign o_rom_addr = i_mirror
                    ? rrom_q + ROM_AW'(SPR_W - 1) - ROM_AW'(col_q)
                    : rrom_q + ROM_AW'(col_q);
  assign o_col      = col_q;
  assign o_row      = row_q;
  assign o_row_base = base_q;

endmodule

// File: rtl/monster_blitter.sv
// Copies one sprite from ROM into the framebuffer at (i_x,i_y) with
// clipping and colour-key transparency; BLIT_MIRROR_EN adds i_mirror.
module monster_blitter
  import blit_pkg::*;
#(
  parameter int         SPR_W  = SPR_W_D,
  parameter int         SPR_H  = SPR_H_D,
  parameter int         ROM_AW = ROM_AW_D,
  parameter int         FB_W   = FB_W_D,
  parameter int         FB_H   = FB_H_D,
  parameter int         FB_AW  = FB_AW_D,
  parameter logic [7:0] TRANSP = TRANSP_D
) (
  input  logic              i_clk2,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_x,
  input  logic [6:0]        i_y,
`ifdef BLIT_MIRROR_EN
  input  logic              i_mirror,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [7:0]        i_rom_data,
  output logic [FB_AW-1:0]  o_fb_addr,
  output logic [7:0]        o_fb_data,
  output logic              o_fb_we
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  logic mirror_in;
`ifdef BLIT_MIRROR_EN
  assign mirror_in = i_mirror;
`else
  assign mirror_in = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic             mir_q, mir_d;

  logic             s1_vld_q, s1_vld_d;
  logic             s1_in_q, s1_in_d;
  logic             s1_last_q, s1_last_d;
  logic [FB_AW-1:0] s1_addr_q, s1_addr_d;

  logic             we_q, we_d;
  logic [FB_AW-1:0] fa_q, fa_d;
  logic [7:0]       fd_q, fd_d;
  logic             wlast_q, wlast_d;

  logic             run;
  logic             g_last;
  logic [CW-1:0]    g_col;
  logic [RW-1:0]    g_row;
  logic [FB_AW-1:0] g_base;
  logic [FB_AW-1:0] base0;
  logic [8:0]       x_sum, y_sum;

  assign run   = (state_q == ST_RUN);
  assign base0 = FB_AW'(i_y) * FB_AW'(FB_W);

  blit_addr_gen #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .ROM_AW (ROM_AW),
    .FB_W   (FB_W),
    .FB_AW  (FB_AW),
    .CW     (CW),
    .RW     (RW)
  ) u_gen (
    .i_clk2     (i_clk2),
    .i_rst      (i_rst),
    .i_clr      (!run),
    .i_step     (run),
    .i_mirror   (run && mir_q),
    .i_base0    (base0),
    .o_rom_addr (o_rom_addr),
    .o_col      (g_col),
    .o_row      (g_row),
    .o_row_base (g_base),
    .o_last     (g_last)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mir_d   = mir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          x_d     = i_x;
          y_d     = i_y;
          mir_d   = mirror_in;
        end
      end
      ST_RUN:   if (g_last) state_d = ST_DRAIN;
      // Leave only once the final pixel's write slot has passed.
      ST_DRAIN: if (wlast_q) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // 9-bit sums so positions past the right/bottom edge never wrap.
  assign x_sum = {1'b0, x_q} + 9'(g_col);
  assign y_sum = 9'(y_q) + 9'(g_row);

  always_comb begin
    s1_vld_d  = run;
    s1_last_d = run && g_last;
    s1_in_d   = (x_sum < 9'(FB_W)) && (y_sum < 9'(FB_H));
    s1_addr_d = g_base + FB_AW'(x_q) + FB_AW'(g_col);
    we_d      = s1_vld_q && s1_in_q && (i_rom_data != TRANSP);
    fa_d      = s1_addr_q;
    fd_d      = i_rom_data;
    wlast_d   = s1_vld_q && s1_last_q;
  end

  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      mir_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_in_q   <= 1'b0;
      s1_last_q <= 1'b0;
      s1_addr_q <= '0;
      we_q      <= 1'b0;
      fa_q      <= '0;
      fd_q      <= '0;
      wlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      mir_q     <= mir_d;
      s1_vld_q  <= s1_vld_d;
      s1_in_q   <= s1_in_d;
      s1_last_q <= s1_last_d;
      s1_addr_q <= s1_addr_d;
      we_q      <= we_d;
      fa_q      <= fa_d;
      fd_q      <= fd_d;
      wlast_q   <= wlast_d;
    end
  end

  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = (state_q == ST_DONE);
  assign o_fb_we   = we_q;
  assign o_fb_addr = fa_q;
  assign o_fb_data = fd_q;

endmodule
